// File: rtl/ula_pkg.sv
// Shared types and constants for the byte-serial ALU and its 8-bit slice.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NBYTES_DEFAULT = 4;

    // Function selects: ADD/SUB with m=0, XOR/AND with m=1 (SUB and XOR share an encoding).
    localparam logic [3:0] ADD = 4'b1001;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] XOR = 4'b0110;
    localparam logic [3:0] AND = 4'b1011;

    // Carry pins are active-low: a high level on c_in/c_out means no carry.
    localparam logic CARRY_NONE = 1'b1;

endpackage

// File: rtl/ula_8_bits.sv
// 8-bit 181-style ALU slice: 16 logic / 16 arithmetic functions, active-low carry in/out.
module ula_8_bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out,
    output logic       a_eq_b,
    output logic       p,
    output logic       g,
    output logic       overflow,
    output logic [7:0] c_intermediate
);
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] chain;
    logic [8:0] gen_sum;

    always_comb begin
        // Arithmetic result is x + y + carry; logic result is the carry-free xnor of the same terms.
        x = a & ((b & {8{s[3]}}) | (~b & {8{s[2]}}));
        y = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        chain = '0;
        chain[0] = ~c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            chain[i+1] = (x[i] & y[i]) | ((x[i] | y[i]) & chain[i]);
        end
        gen_sum = {1'b0, x} + {1'b0, y};
        f = m ? ~(x ^ y) : (x ^ y ^ chain[7:0]);
        c_out = ~chain[8];
        overflow = ~m & (chain[8] ^ chain[7]);
        a_eq_b = &f;
        p = &(x | y);
        g = gen_sum[8];
        c_intermediate = chain[7:0];
    end

endmodule

// File: rtl/ula_seq_32.sv
// Byte-serial ALU: one ula_8_bits pass per cycle, carry chained through a register.
module ula_seq_32
    import ula_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    input  logic [3:0]          req_s,
    input  logic                req_m,
    input  logic                req_c_in,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*NBYTES-1:0] res_f,
    output logic                res_c_out,
    output logic                res_overflow,
    output logic                res_a_eq_b,
    output logic                busy
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [3:0]    s_reg;
    logic          m_reg;
    logic [IW-1:0] idx;
    logic          carry_reg;
    logic          eq_acc;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [7:0]    f_byte;
    logic          c_out;
    logic          overflow;
    logic          a_eq_b;
    logic          accept;
    logic          last;

    assign accept = req_valid && (state == IDLE);
    assign last   = (idx == LAST);
    assign a_byte = a_reg[8*idx +: 8];
    assign b_byte = b_reg[8*idx +: 8];

    ula_8_bits u_ula (
        .a             (a_byte),
        .b             (b_byte),
        .s             (s_reg),
        .m             (m_reg),
        .c_in          (carry_reg),
        .f             (f_byte),
        .c_out         (c_out),
        .a_eq_b        (a_eq_b),
        .p             (),
        .g             (),
        .overflow      (overflow),
        .c_intermediate()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_valid) state_next = RUN;
            RUN:  if (last)      state_next = DONE;
            DONE: if (res_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            s_reg        <= '0;
            m_reg        <= 1'b0;
            idx          <= '0;
            carry_reg    <= 1'b0;
            eq_acc       <= 1'b1;
            res_f        <= '0;
            res_c_out    <= 1'b0;
            res_overflow <= 1'b0;
            res_a_eq_b   <= 1'b0;
        end else if (accept) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            s_reg     <= req_s;
            m_reg     <= req_m;
            idx       <= '0;
            carry_reg <= req_c_in;
            eq_acc    <= 1'b1;
        end else if (state == RUN) begin
            res_f[8*idx +: 8] <= f_byte;
            carry_reg         <= c_out;
            eq_acc            <= eq_acc & a_eq_b;
            // idx parks at zero after the final pass so it never steps past NBYTES-1.
            if (last) begin
                idx          <= '0;
                res_c_out    <= c_out;
                res_overflow <= overflow;
                res_a_eq_b   <= eq_acc & a_eq_b;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_seq_32.sv
// Directed and randomized checks of ula_seq_32 against a word-level reference model.
module tb_ula_seq_32;
    import ula_pkg::*;

    localparam int unsigned NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_s;
    logic        req_m;
    logic        req_c_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_f;
    logic        res_c_out;
    logic        res_overflow;
    logic        res_a_eq_b;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ula_seq_32 #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_s       (req_s),
        .req_m       (req_m),
        .req_c_in    (req_c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_f       (res_f),
        .res_c_out   (res_c_out),
        .res_overflow(res_overflow),
        .res_a_eq_b  (res_a_eq_b),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word model: carries are active-low, a_eq_b means the result is all ones.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                                  input logic m, input logic c_in,
                                  output logic [31:0] f, output logic co, output logic ov,
                                  output logic eq);
        logic [32:0] sum;
        logic [32:0] cy;
        cy = {32'd0, ~c_in};
        if (s == ADD)      sum = {1'b0, a} + {1'b0, b} + cy;
        else if (s == SUB) sum = {1'b0, a} + {1'b0, ~b} + cy;
        else               sum = {1'b0, a & b} + {1'b0, 32'hFFFF_FFFF} + cy;
        co = ~sum[32];
        if (m) begin
            f  = (s == XOR) ? (a ^ b) : (a & b);
            ov = 1'b0;
        end else begin
            f = sum[31:0];
            if (s == ADD) ov = (a[31] == b[31]) && (f[31] != a[31]);
            else          ov = (a[31] != b[31]) && (f[31] != a[31]);
        end
        eq = (f == 32'hFFFF_FFFF);
    endfunction

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, input logic m, input logic c, input int hold);
        logic [31:0] ef;
        logic ec, eo, ee;
        int n;
        model(a, b, s, m, c, ef, ec, eo, ee);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = c;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, NB);
        chk({tag, "_f"}, res_f, ef);
        chk({tag, "_cout"}, res_c_out, ec);
        chk({tag, "_ovf"}, res_overflow, eo);
        chk({tag, "_eq"}, res_a_eq_b, ee);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_s = ADD; req_m = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, res_valid, 1'b1);
            chk({tag, "_hold_f"}, res_f, ef);
            chk({tag, "_hold_flags"}, {res_c_out, res_overflow, res_a_eq_b}, {ec, eo, ee});
            chk({tag, "_hold_ready"}, {req_ready, busy}, 2'b01);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_release"}, {res_valid, req_ready, busy}, 3'b010);
        chk({tag, "_retain_f"}, res_f, ef);
    endtask

    initial begin
        int sel;
        int seen;
        logic [31:0] ra, rb;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0;
        req_m = 1'b0; req_c_in = CARRY_NONE; res_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_outputs", {res_valid, busy, req_ready, res_c_out, res_overflow, res_a_eq_b}, 6'b001000);
        chk("rst_f", res_f, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", req_ready, 1'b1);

        do_op("carry_ripple", 32'h0000_00FF, 32'h0000_0001, ADD, 1'b0, CARRY_NONE, 0);
        do_op("signed_ovf",   32'h7FFF_FFFF, 32'h0000_0001, ADD, 1'b0, CARRY_NONE, 0);
        do_op("logic_xor",    32'hA5A5_A5A5, 32'h0F0F_0F0F, XOR, 1'b1, CARRY_NONE, 1);
        do_op("logic_and",    32'hF0F0_1234, 32'h0FF0_FF00, AND, 1'b1, 1'b0, 0);
        do_op("eq_same",      32'h1234_5678, 32'h1234_5678, SUB, 1'b0, CARRY_NONE, 0);
        do_op("eq_flip",      32'h1234_5678, 32'h9234_5678, SUB, 1'b0, CARRY_NONE, 0);
        do_op("add_cin",      32'hFFFF_FFFF, 32'h0000_0000, ADD, 1'b0, 1'b0, 0);
        do_op("backpressure", 32'hDEAD_BEEF, 32'h0123_4567, ADD, 1'b0, CARRY_NONE, 10);

        // Reset while RUN is on its third pass.
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'h5555_5555; req_b = 32'h3333_3333;
        req_s = ADD; req_m = 1'b0; req_c_in = CARRY_NONE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_outputs", {res_valid, busy, req_ready, res_c_out, res_overflow, res_a_eq_b}, 6'b001000);
        chk("midrun_rst_f", res_f, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (res_valid) seen++; end
        chk("midrun_no_valid", seen, 0);
        do_op("after_rst", 32'h5555_5555, 32'h3333_3333, ADD, 1'b0, CARRY_NONE, 0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(3);
            ra = $urandom;
            rb = ($urandom_range(3) == 0) ? ra : 32'($urandom);
            case (sel)
                0: do_op($sformatf("rnd%0d_add", k), ra, rb, ADD, 1'b0, 1'($urandom), $urandom_range(2));
                1: do_op($sformatf("rnd%0d_sub", k), ra, rb, SUB, 1'b0, 1'($urandom), $urandom_range(2));
                2: do_op($sformatf("rnd%0d_xor", k), ra, rb, XOR, 1'b1, 1'($urandom), $urandom_range(2));
                default: do_op($sformatf("rnd%0d_and", k), ra, rb, AND, 1'b1, 1'($urandom), $urandom_range(2));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
